// File: rtl/sw_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_capture_pkg
// Purpose  : Shared register map, debounce counter width and reset limit.
// Revision : 1.0 - initial release
// ============================================================================
package sw_capture_pkg;

  localparam int DB_CNT_W   = 20;
  localparam int DB_DEFAULT = 50000;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_DBLIM = 2'd3;

  // Terminal counter value for a given limit; a zero limit behaves as one.
  function automatic logic [DB_CNT_W-1:0] db_last(input logic [DB_CNT_W-1:0] lim);
    return (lim == '0) ? '0 : lim - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Single-bit 2-flop synchronizer followed by a run-length debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_sw,
  input  logic                                i_cnt_clr,
  input  logic [sw_capture_pkg::DB_CNT_W-1:0] i_last,
  output logic                                o_stable,
  output logic                                o_toggle
);
  import sw_capture_pkg::*;

  logic                r_meta;
  logic                r_sync;
  logic                r_stable;
  logic [DB_CNT_W-1:0] r_cnt;
  logic                w_diff;
  logic                w_toggle;

  assign w_diff   = r_sync ^ r_stable;
  // A pending limit rewrite restarts the count, so it also suppresses a toggle.
  assign w_toggle = w_diff && (r_cnt == i_last) && !i_cnt_clr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      if (i_cnt_clr || !w_diff || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_toggle) begin
        r_stable <= r_sync;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_toggle = w_toggle;

endmodule
`default_nettype wire

// File: rtl/sw_capture_slave.sv
`default_nettype none
// ============================================================================
// Module   : sw_capture_slave
// Purpose  : Debounced switch capture with edge latching, masked interrupt
//            and an Avalon-MM register slave (read latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module sw_capture_slave #(
  parameter int WIDTH      = 4,
  parameter int DB_DEFAULT = sw_capture_pkg::DB_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);
  import sw_capture_pkg::DB_CNT_W;
  import sw_capture_pkg::ADDR_DATA;
  import sw_capture_pkg::ADDR_EDGE;
  import sw_capture_pkg::ADDR_MASK;
  import sw_capture_pkg::ADDR_DBLIM;
  import sw_capture_pkg::db_last;

  logic [WIDTH-1:0]    w_stable;
  logic [WIDTH-1:0]    w_toggle;
  logic [WIDTH-1:0]    w_edge_clr;
  logic [WIDTH-1:0]    r_edge;
  logic [WIDTH-1:0]    r_mask;
  logic [DB_CNT_W-1:0] r_dblim;
  logic [DB_CNT_W-1:0] w_last;
  logic [31:0]         w_rd_mux;
  logic [31:0]         r_readdata;
  logic                r_irq;
  logic                w_wr;
  logic                w_rd;
  logic                w_dblim_wr;
  logic                w_unused_wdata;

  assign w_wr           = avs_chipselect & avs_write;
  assign w_rd           = avs_chipselect & avs_read;
  assign w_dblim_wr     = w_wr && (avs_address == ADDR_DBLIM);
  assign w_edge_clr     = (w_wr && (avs_address == ADDR_EDGE)) ? avs_writedata[WIDTH-1:0] : '0;
  assign w_last         = db_last(r_dblim);
  assign w_unused_wdata = ^avs_writedata[31:DB_CNT_W];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_sw      (sw_in[gi]),
        .i_cnt_clr (w_dblim_wr),
        .i_last    (w_last),
        .o_stable  (w_stable[gi]),
        .o_toggle  (w_toggle[gi])
      );
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_DATA:  w_rd_mux[WIDTH-1:0]    = w_stable;
      ADDR_EDGE:  w_rd_mux[WIDTH-1:0]    = r_edge;
      ADDR_MASK:  w_rd_mux[WIDTH-1:0]    = r_mask;
      ADDR_DBLIM: w_rd_mux[DB_CNT_W-1:0] = r_dblim;
      default:    w_rd_mux               = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_edge     <= '0;
      r_mask     <= '0;
      r_dblim    <= DB_CNT_W'(DB_DEFAULT);
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      // Set is OR-ed in after the clear so a coincident new edge survives.
      r_edge <= (r_edge & ~w_edge_clr) | w_toggle;
      if (w_wr && (avs_address == ADDR_MASK)) begin
        r_mask <= avs_writedata[WIDTH-1:0];
      end
      if (w_dblim_wr) begin
        r_dblim <= avs_writedata[DB_CNT_W-1:0];
      end
      r_readdata <= w_rd ? w_rd_mux : '0;
      r_irq      <= |(r_edge & r_mask);
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sw_capture_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_capture_slave
// Purpose  : Self-checking bench: register table, directed corners, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_capture_slave;
  localparam int W   = 4;
  localparam int DBD = 50000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  sw_in = '0;
  logic [1:0]    avs_address = '0;
  logic          avs_chipselect = 1'b0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;

  always #5 clk = ~clk;

  sw_capture_slave #(.WIDTH(W), .DB_DEFAULT(DBD)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sw_in          (sw_in),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .irq            (irq)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, in terms of the externally visible behaviour.
  logic [W-1:0]  m_s1, m_s2, m_stable, m_edge, m_mask;
  logic [19:0]   m_dblim;
  logic [31:0]   m_rdata;
  logic          m_irq;
  int            m_run[W];

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  logic [31:0] d;
  logic        prev_irq;
  logic        found;
  logic [1:0]  ra;
  logic [31:0] rd_v;
  int          j;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic cs, input logic rd, input logic wr,
                     input logic [1:0] a, input logic [31:0] wd);
    avs_chipselect = cs;
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = a;
    avs_writedata  = wd;
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT, compare.
  task automatic step();
    logic [W-1:0] nstable, set_b, clr_b;
    logic [31:0]  rv;
    int           eff;
    bit           dbw;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_edge = '0; m_mask = '0;
      m_dblim = 20'(DBD); m_rdata = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      dbw     = avs_chipselect && avs_write && (avs_address == 2'd3);
      eff     = (m_dblim == 0) ? 1 : int'(m_dblim);
      nstable = m_stable;
      set_b   = '0;
      for (int i = 0; i < W; i++) begin
        if (dbw || (m_s2[i] == m_stable[i])) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] >= eff) begin
            nstable[i] = ~m_stable[i];
            set_b[i]   = 1'b1;
            m_run[i]   = 0;
          end
        end
      end
      case (avs_address)
        2'd0:    rv = {28'b0, m_stable};
        2'd1:    rv = {28'b0, m_edge};
        2'd2:    rv = {28'b0, m_mask};
        default: rv = {12'b0, m_dblim};
      endcase
      m_rdata = (avs_chipselect && avs_read) ? rv : 32'h0;
      m_irq   = |(m_edge & m_mask);
      clr_b   = (avs_chipselect && avs_write && avs_address == 2'd1) ? avs_writedata[W-1:0] : '0;
      m_edge  = (m_edge & ~clr_b) | set_b;
      if (avs_chipselect && avs_write && avs_address == 2'd2) m_mask = avs_writedata[W-1:0];
      if (dbw) m_dblim = avs_writedata[19:0];
      m_s2     = m_s1;
      m_s1     = sw_in;
      m_stable = nstable;
    end
    @(posedge clk);
    #1;
    check("rdata_model", avs_readdata, m_rdata);
    check("irq_model", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    bus(1'b1, 1'b1, 1'b0, a, 32'h0);
    step();
    v = avs_readdata;
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFA5, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,         32'h5};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h3,         32'h5};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,         32'h3};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h0,         32'h000F_FFFF};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'hF,         32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'hF,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,         32'h3};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h4,         32'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h0,         32'h4};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0,         32'h3};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,         32'h0};

    // Reset state
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    rd_reg(2'd3, d); check("reset_dblim", d, 32'd50000);
    rd_reg(2'd0, d); check("reset_data", d, 32'h0);

    // Register access table
    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      step();
      check($sformatf("vec%0d", i), avs_readdata, vecs[i].exp);
    end
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // Held switch: DATA visible exactly 2+4 cycles after the change
    sw_in = 4'h1;
    bus(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("data_cyc%0d", k), avs_readdata, (k == 7) ? 32'h1 : 32'h0);
    end
    rd_reg(2'd1, d); check("edge_bit0", d, 32'h1);
    check("irq_masked", {31'b0, irq}, 32'h0);
    bus(1'b1, 1'b0, 1'b1, 2'd1, 32'h1); step();
    rd_reg(2'd1, d); check("edge_cleared", d, 32'h0);

    // Short glitch on bit 1 is rejected
    sw_in = 4'h3;
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    repeat (3) step();
    sw_in = 4'h1;
    repeat (8) step();
    rd_reg(2'd0, d); check("glitch_data", d, 32'h1);
    rd_reg(2'd1, d); check("glitch_edge", d, 32'h0);

    // Interrupt timing on bit 2
    bus(1'b1, 1'b0, 1'b1, 2'd2, 32'hF); step();
    sw_in = 4'h5;
    bus(1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
    found = 1'b0;
    prev_irq = irq;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (avs_readdata[2]) begin
        found = 1'b1;
        check("irq_with_edge", {31'b0, irq}, 32'h1);
        check("irq_before_edge", {31'b0, prev_irq}, 32'h0);
      end
      prev_irq = irq;
    end
    check("edge2_seen", {31'b0, found}, 32'h1);
    bus(1'b1, 1'b0, 1'b1, 2'd1, 32'h4); step();
    check("irq_after_clr1", {31'b0, irq}, 32'h1);
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); step();
    check("irq_after_clr2", {31'b0, irq}, 32'h0);

    // W1C coincident with bit 3 setting: set wins
    sw_in = 4'hD;
    repeat (5) step();
    bus(1'b1, 1'b0, 1'b1, 2'd1, 32'h8); step();
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    rd_reg(2'd1, d); check("edge_set_wins", d, 32'h8);
    bus(1'b1, 1'b0, 1'b1, 2'd1, 32'h8); step();
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // DBLIM rewrite mid-count restarts the count
    bus(1'b1, 1'b0, 1'b1, 2'd3, 32'd10); step();
    sw_in = 4'hC;
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    repeat (4) step();
    bus(1'b1, 1'b0, 1'b1, 2'd3, 32'h0000_0003); step();
    bus(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("dblim_restart%0d", k), avs_readdata, (k == 3) ? 32'hC : 32'hD);
    end
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, W - 1);
        sw_in[j] ^= 1'b1;
      end
      ra   = 2'($urandom_range(0, 3));
      rd_v = $urandom();
      if (ra == 2'd3) rd_v = (rd_v & 32'hFFF0_0000) | 32'($urandom_range(0, 6));
      bus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, ra, rd_v);
      step();
    end
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // Reset with all edges pending and fully unmasked
    bus(1'b1, 1'b0, 1'b1, 2'd3, 32'h1); step();
    bus(1'b1, 1'b0, 1'b1, 2'd2, 32'hF); step();
    bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    sw_in = ~m_stable;
    repeat (6) step();
    rd_reg(2'd1, d); check("edge_all", d, 32'hF);
    check("irq_all", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    sw_in   = '0;
    step();
    reset_n = 1'b1;
    rd_reg(2'd0, d); check("rst_data", d, 32'h0);
    rd_reg(2'd1, d); check("rst_edge", d, 32'h0);
    rd_reg(2'd2, d); check("rst_mask", d, 32'h0);
    rd_reg(2'd3, d); check("rst_dblim", d, 32'd50000);
    check("rst_irq", {31'b0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sw_capture_slave.md
SW_CAPTURE_SLAVE -- requirements
Module: sw_capture_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of switch inputs (1..28).
REQ-002 SHALL have parameter DB_DEFAULT, default 50000, reset value of the debounce limit in clk cycles (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sw_in  input  WIDTH  raw asynchronous switch levels from board pins.
REQ-006 SHALL have port avs_address  input  2  Avalon-MM word address.
REQ-007 SHALL have port avs_chipselect  input  1  slave select.
REQ-008 SHALL have port avs_read  input  1  read strobe.
REQ-009 SHALL have port avs_write  input  1  write strobe.
REQ-010 SHALL have port avs_writedata  input  32  write data.
REQ-011 SHALL have port avs_readdata  output  32  read data, fixed read latency 1, no waitrequest.
REQ-012 SHALL have port irq  output  1  level interrupt to the HPS.

Function
REQ-013 SHALL pass sw_in through a 2-flop synchronizer per bit; sync latency 2 cycles.
REQ-014 SHALL keep per bit a stable value and a 20-bit counter: synced != stable -> counter +1; synced == stable -> counter cleared.
REQ-015 SHALL update the stable bit and clear its counter when the counter reaches db_limit-1, i.e. after db_limit consecutive differing cycles; db_limit 0 treated as 1.
REQ-016 SHALL set edge[i] on any change of stable[i] (rising or falling).
REQ-017 SHALL clear edge bits written as 1 to address 1; simultaneous set and clear of the same bit -> set wins.
REQ-018 SHALL register map: 0 DATA (RO, stable, zero-extended); 1 EDGE (W1C); 2 MASK (RW, WIDTH bits); 3 DBLIM (RW, 20 bits).
REQ-019 SHALL ignore writes to address 0 and write bits above the field width; unused read bits return 0.
REQ-020 SHALL clear all debounce counters in the cycle after a DBLIM write; stable values are retained.
REQ-021 SHALL register avs_readdata one cycle after chipselect&read; drive 0 in all other cycles; reads have no side effects.
REQ-022 SHALL, on simultaneous read and write, perform the write and return the pre-write register value.
REQ-023 SHALL drive irq as a register of |(edge & mask); it asserts 1 cycle after the enabling edge/mask update.

Reset
REQ-024 SHALL, on reset_n low at a clk edge: synchronizers, stable, counters, edge, mask, avs_readdata and irq = 0; DBLIM = DB_DEFAULT.
REQ-025 SHALL abandon any partial debounce on reset; switches held high at reset release report 1 after 2+db_limit cycles and set edge.

Structure
REQ-026 SHALL place register address constants, DB counter width (20) and DB_DEFAULT in shared package sw_capture_pkg.
REQ-027 SHALL implement the per-bit synchronizer+debouncer as sub-module sw_debounce, instantiated WIDTH times.

Verification
REQ-028 SHALL cover: DBLIM=4, sw_in[0] 0->1 held -> DATA reads 0x1 after exactly 6 cycles, EDGE=0x1; irq stays 0 with MASK=0.
REQ-029 SHALL cover: DBLIM=4, sw_in[1] pulses high 3 cycles -> DATA stays 0x0, EDGE stays 0x0.
REQ-030 SHALL cover: MASK=0xF, edge on bit 2 -> irq=1 one cycle after EDGE bit sets; write 0x4 to EDGE -> irq=0 two cycles later.
REQ-031 SHALL cover: W1C write to EDGE in the same cycle bit 3 sets -> EDGE reads 0x8.
REQ-032 SHALL cover: DBLIM write 0x00003 mid-count (counter=2, old limit 10) -> counter restarts, stable changes 3 cycles later.
REQ-033 SHALL cover: reset_n low for 1 cycle with EDGE=0xF, MASK=0xF -> all registers 0, DBLIM reads 50000, irq=0.
